position_to_onehot_board_encoder: RTL and testbench
===================================================

// Module: position_to_onehot_board_encoder
// PURPOSE
//  Board-side inverse of the one-hot row decoder in the 8-Queen datapath.
//  The solver writes (row, column) queen placements or removals; each column
//  is encoded to one-hot and held in an N-row board register.
//  On request, streams the board out one one-hot row per beat under
//  valid/ready, for display or check logic.
// PARAMETERS
//  N      8          board size (rows = columns = N), 2..16
//  COL_W  $clog2(N)  width of row/column indices
// PORTS
//  clk           in   1      rising-edge clock
//  rst_n         in   1      asynchronous, active-low reset
//  clear         in   1      synchronous board clear; aborts any dump
//  in_valid      in   1      placement request valid
//  in_ready      out  1      placement accepted when in_valid & in_ready
//  in_row        in   COL_W  target row
//  in_col        in   COL_W  queen column (ignored when in_remove=1)
//  in_remove     in   1      1 = remove the queen from in_row
//  dump_start    in   1      1-cycle request to stream the board
//  out_valid     out  1      out_onehot/out_row_idx valid
//  out_ready     in   1      sink accepts beat
//  out_row_idx   out  COL_W  row index of current beat
//  out_onehot    out  [0:N-1] one-hot row; bit 0 = column 0 (MSB-first)
//  out_last      out  1      current beat is row N-1
//  occupied      out  [0:N-1] bit r = row r holds a queen
//  busy          out  1      dump in progress
//  conflict      out  1      attack detected on last accepted write
// BEHAVIOUR
//  Reset (rst_n=0, async): board all zero; state IDLE; out_valid=0;
//   out_row_idx=0; conflict=0. in_ready and busy follow from IDLE.
//  States: IDLE (accept writes), DUMP (stream rows).
//  IDLE: in_ready=1. An accepted write sets board[in_row] to onehot(in_col),
//   or to all-zero if in_remove=1. The new value is visible on the next cycle.
//  in_row >= N: handshake completes, board unchanged.
//  in_col >= N: treated as a removal.
//  dump_start in IDLE -> DUMP on the next edge. out_valid=1 from the first
//   DUMP cycle with row 0.
//  A write and dump_start in the same cycle: the write is accepted, and the
//   dump reflects it.
//  DUMP: in_ready=0; busy=1. out_onehot = board[out_row_idx], stable while
//   out_valid & !out_ready. Each handshake increments out_row_idx.
//   out_last = (out_row_idx == N-1).
//  The handshake on the last row -> IDLE with out_row_idx=0 and out_valid=0
//   on the next cycle. No bubble between beats.
//  dump_start while in DUMP is ignored; no queuing.
//  clear (sync, highest priority): board <= 0; state -> IDLE; out_valid=0;
//   out_row_idx=0; conflict=0. A write in the same cycle is dropped.
//  Reset mid-dump: immediate return to the reset state; the sink sees
//   out_valid drop asynchronously.
//  occupied[r] = |board[r]| (combinational from the register).
// CONFIGURATION
//  CONFLICT_CHECK_EN defined: on an accepted non-remove write with valid
//   row/col, conflict is registered for exactly one cycle (next cycle).
//   It is set if any other occupied row r has the same column, or
//   |r-in_row| == |col(r)-in_col|. The write is still performed.
//  CONFLICT_CHECK_EN undefined: conflict tied to 0; no checking logic.
// STRUCTURE
//  queen_pkg: N/COL_W defaults, state typedef {IDLE, DUMP}, onehot width
//   localparam.
//  Sub-module pos_to_onehot: combinational COL_W -> [0:N-1] encoder;
//   out-of-range input gives zero.
//  Top level holds the board registers, FSM, row counter and optional
//   conflict comparator array.
// TESTING
//  Write row2 col5, dump, out_ready=1 -> beat 2 = 0000_0100,
//   others 0; out_last on beat 7.
//  Dump with out_ready toggling 1/0 -> each row is held until accepted,
//   8 beats in order, busy low after the last.
//  Write row3 col1 and dump_start in one cycle -> beat 3 = 0100_0000.
//  clear at beat 4 of a dump -> out_valid=0 next cycle, occupied=0,
//   in_ready=1.
//  CONFLICT_CHECK_EN: rows 0/col0, then 1/col1 -> conflict pulses 1 cycle;
//   then 2/col3 after removing row1 -> no pulse.
//  rst_n low mid-dump, then high -> out_valid=0, board zero, in_ready=1.

Source files
------------

// File: rtl/queen_pkg.sv
// Shared board-size defaults, FSM state type and helpers for the queen board encoder.
package queen_pkg;

    localparam int unsigned N_DEF     = 8;
    localparam int unsigned COL_W_DEF = $clog2(N_DEF);
    localparam int unsigned ONEHOT_W  = N_DEF;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DUMP = 1'b1
    } state_t;

    // Absolute difference of two board coordinates.
    function automatic int abs_diff(input int a, input int b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/pos_to_onehot.sv
// Column index to MSB-first one-hot row; out-of-range index gives all zero.
module pos_to_onehot #(
    parameter int unsigned N     = 8,
    parameter int unsigned COL_W = $clog2(N)
) (
    input  logic [COL_W-1:0] col,
    output logic [0:N-1]     onehot_c
);

    // Compare against every legal column so out-of-range values match nothing.
    always_comb begin
        onehot_c = '0;
        for (int i = 0; i < int'(N); i++) begin
            onehot_c[i] = (col == COL_W'(i));
        end
    end

endmodule

// File: rtl/position_to_onehot_board_encoder.sv
// N-row one-hot queen board: accepts row/column placements, streams rows out
// under valid/ready. Optional attack detection enabled by CONFLICT_CHECK_EN.
module position_to_onehot_board_encoder
    import queen_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned COL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [COL_W-1:0] in_row,
    input  logic [COL_W-1:0] in_col,
    input  logic             in_remove,
    input  logic             dump_start,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [COL_W-1:0] out_row_idx,
    output logic [0:N-1]     out_onehot,
    output logic             out_last,
    output logic [0:N-1]     occupied,
    output logic             busy,
    output logic             conflict
);

    state_t           state;
    logic [0:N-1]     board [N];
    logic [0:N-1]     wr_onehot_c;
    logic [0:N-1]     wr_value_c;
    logic             accept_c;

    pos_to_onehot #(
        .N     (N),
        .COL_W (COL_W)
    ) u_enc (
        .col      (in_col),
        .onehot_c (wr_onehot_c)
    );

    assign in_ready    = (state == IDLE);
    assign busy        = (state == DUMP);
    assign accept_c    = in_valid && in_ready;
    assign wr_value_c  = in_remove ? '0 : wr_onehot_c;
    assign out_onehot  = board[out_row_idx];
    assign out_last    = (out_row_idx == COL_W'(N - 1));

    // Row occupancy straight from the board register.
    always_comb begin
        occupied = '0;
        for (int r = 0; r < int'(N); r++) begin
            occupied[r] = |board[r];
        end
    end

    // Board storage: writes only land in IDLE; out-of-range rows match no entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < int'(N); r++) begin
                board[r] <= '0;
            end
        end else if (clear) begin
            for (int r = 0; r < int'(N); r++) begin
                board[r] <= '0;
            end
        end else if (accept_c) begin
            for (int r = 0; r < int'(N); r++) begin
                if (in_row == COL_W'(r)) begin
                    board[r] <= wr_value_c;
                end
            end
        end
    end

    // Dump FSM with registered valid and row counter; no bubble between beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            out_row_idx <= '0;
        end else if (clear) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            out_row_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dump_start) begin
                        state       <= DUMP;
                        out_valid   <= 1'b1;
                        out_row_idx <= '0;
                    end
                end
                DUMP: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state       <= IDLE;
                            out_valid   <= 1'b0;
                            out_row_idx <= '0;
                        end else begin
                            out_row_idx <= out_row_idx + COL_W'(1);
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid   <= 1'b0;
                    out_row_idx <= '0;
                end
            endcase
        end
    end

`ifdef CONFLICT_CHECK_EN
    logic hit_c;
    logic col_ok_c;
    logic row_ok_c;

    assign col_ok_c = (32'(in_col) < N);
    assign row_ok_c = (32'(in_row) < N);

    // Any other occupied row sharing the column or a diagonal with the write.
    always_comb begin
        hit_c = 1'b0;
        for (int r = 0; r < int'(N); r++) begin
            for (int c = 0; c < int'(N); c++) begin
                if (board[r][c] && (r != int'(in_row))) begin
                    if (c == int'(in_col)) begin
                        hit_c = 1'b1;
                    end
                    if (abs_diff(r, int'(in_row)) == abs_diff(c, int'(in_col))) begin
                        hit_c = 1'b1;
                    end
                end
            end
        end
    end

    // One-cycle conflict pulse after an accepted in-range placement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict <= 1'b0;
        end else if (clear) begin
            conflict <= 1'b0;
        end else begin
            conflict <= accept_c && !in_remove && row_ok_c && col_ok_c && hit_c;
        end
    end
`else
    assign conflict = 1'b0;
`endif

endmodule

// File: tb/tb_position_to_onehot_board_encoder.sv
// Directed self-checking bench for position_to_onehot_board_encoder (N=8).
module tb_position_to_onehot_board_encoder;

    localparam int unsigned N     = 8;
    localparam int unsigned COL_W = 3;

    logic             clk;
    logic             rst_n;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [COL_W-1:0] in_row;
    logic [COL_W-1:0] in_col;
    logic             in_remove;
    logic             dump_start;
    logic             out_valid;
    logic             out_ready;
    logic [COL_W-1:0] out_row_idx;
    logic [0:N-1]     out_onehot;
    logic             out_last;
    logic [0:N-1]     occupied;
    logic             busy;
    logic             conflict;

    int n_cmp;
    int n_err;

    position_to_onehot_board_encoder #(
        .N     (N),
        .COL_W (COL_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_row      (in_row),
        .in_col      (in_col),
        .in_remove   (in_remove),
        .dump_start  (dump_start),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row_idx (out_row_idx),
        .out_onehot  (out_onehot),
        .out_last    (out_last),
        .occupied    (occupied),
        .busy        (busy),
        .conflict    (conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one write for a single cycle, return at the following negedge.
    task automatic wr(input int row, input int col, input logic rem, input logic dstart);
        in_valid   = 1'b1;
        in_row     = COL_W'(row);
        in_col     = COL_W'(col);
        in_remove  = rem;
        dump_start = dstart;
        @(negedge clk);
        in_valid   = 1'b0;
        in_remove  = 1'b0;
        dump_start = 1'b0;
    endtask

    // Expected board content (display order, bit 0 = column 0 = MSB).
    logic [7:0] exp_row [8];

    initial begin
        int e;
        int cyc;
        logic rdy;

        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 8; i++) exp_row[i] = 8'h00;

        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_row = '0; in_col = '0;
        in_remove = 1'b0; dump_start = 1'b0; out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_row_idx",   32'(out_row_idx), 32'd0);
        chk("rst_conflict",  32'(conflict), 32'd0);
        chk("rst_in_ready",  32'(in_ready), 32'd1);
        chk("rst_busy",      32'(busy), 32'd0);
        chk("rst_occupied",  32'(occupied), 32'h00);
        rst_n = 1'b1;
        @(negedge clk);

        // Row 2 col 5, full-speed dump
        wr(2, 5, 1'b0, 1'b0);
        exp_row[2] = 8'h04;
        chk("occ_row2", 32'(occupied), 32'h20);
        out_ready  = 1'b1;
        dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        for (int b = 0; b < 8; b++) begin
            chk("d1_valid",  32'(out_valid), 32'd1);
            chk("d1_row",    32'(out_row_idx), 32'(b));
            chk("d1_onehot", 32'(out_onehot), 32'(exp_row[b]));
            chk("d1_last",   32'(out_last), (b == 7) ? 32'd1 : 32'd0);
            chk("d1_busy",   32'(busy), 32'd1);
            chk("d1_in_rdy", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        chk("d1_end_valid", 32'(out_valid), 32'd0);
        chk("d1_end_busy",  32'(busy), 32'd0);
        chk("d1_end_row",   32'(out_row_idx), 32'd0);
        chk("d1_end_inrdy", 32'(in_ready), 32'd1);

        // Row 6 col 0, dump with out_ready toggling
        wr(6, 0, 1'b0, 1'b0);
        exp_row[6] = 8'h80;
        out_ready  = 1'b0;
        dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        e = 0;
        cyc = 0;
        while (e < 8 && cyc < 40) begin
            chk("d2_valid",  32'(out_valid), 32'd1);
            chk("d2_row",    32'(out_row_idx), 32'(e));
            chk("d2_onehot", 32'(out_onehot), 32'(exp_row[e]));
            rdy = (cyc % 2) == 1;
            out_ready = rdy;
            @(negedge clk);
            if (rdy) e++;
            cyc++;
        end
        chk("d2_beats", 32'(e), 32'd8);
        chk("d2_end_busy",  32'(busy), 32'd0);
        chk("d2_end_valid", 32'(out_valid), 32'd0);

        // Write row 3 col 1 together with dump_start
        out_ready = 1'b1;
        wr(3, 1, 1'b0, 1'b1);
        exp_row[3] = 8'h40;
        for (int b = 0; b < 8; b++) begin
            chk("d3_row",    32'(out_row_idx), 32'(b));
            chk("d3_onehot", 32'(out_onehot), 32'(exp_row[b]));
            @(negedge clk);
        end
        chk("d3_end_busy", 32'(busy), 32'd0);

        // Clear at beat 4 of a dump
        dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        for (int b = 0; b < 4; b++) @(negedge clk);
        chk("clr_at_row4", 32'(out_row_idx), 32'd4);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_valid",    32'(out_valid), 32'd0);
        chk("clr_occupied", 32'(occupied), 32'h00);
        chk("clr_in_ready", 32'(in_ready), 32'd1);
        chk("clr_row",      32'(out_row_idx), 32'd0);
        for (int i = 0; i < 8; i++) exp_row[i] = 8'h00;

        // Clear drops a same-cycle write
        clear = 1'b1;
        wr(5, 5, 1'b0, 1'b0);
        clear = 1'b0;
        chk("clr_drop_wr", 32'(occupied), 32'h00);

        // Place and remove
        wr(4, 2, 1'b0, 1'b0);
        chk("place_r4", 32'(occupied), 32'h08);
        wr(4, 0, 1'b1, 1'b0);
        chk("remove_r4", 32'(occupied), 32'h00);

        // Conflict detection
        wr(0, 0, 1'b0, 1'b0);
        chk("cf_first", 32'(conflict), 32'd0);
        wr(1, 1, 1'b0, 1'b0);
`ifdef CONFLICT_CHECK_EN
        chk("cf_diag_pulse", 32'(conflict), 32'd1);
`else
        chk("cf_disabled", 32'(conflict), 32'd0);
`endif
        @(negedge clk);
        chk("cf_pulse_end", 32'(conflict), 32'd0);
        wr(1, 0, 1'b1, 1'b0);
        chk("cf_remove", 32'(conflict), 32'd0);
        wr(2, 3, 1'b0, 1'b0);
        chk("cf_safe", 32'(conflict), 32'd0);
        chk("cf_occ", 32'(occupied), 32'hA0);

        // Reset mid-dump
        dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rd_mid_row", 32'(out_row_idx), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rd_async_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rd_valid",    32'(out_valid), 32'd0);
        chk("rd_occupied", 32'(occupied), 32'h00);
        chk("rd_in_ready", 32'(in_ready), 32'd1);
        chk("rd_busy",     32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
